// File: rtl/servo_pkg.sv
// Shared servo PWM constants and decoder state type.
// The generator imports the same mapping so both ends agree.
package servo_pkg;

  localparam int DC_MIN     = 25;
  localparam int DC_MAX     = 125;
  localparam int PULSE_MIN  = 25_000;
  localparam int PULSE_MAX  = 125_000;
  localparam int STEP       = 1_000;
  localparam int TOL        = 2_500;
  localparam int PERIOD_MAX = 1_200_000;

  typedef enum logic [1:0] {
    SYNC,
    WAIT_RISE,
    HIGH
  } state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer with registered rise/fall detection.
// primed marks when the synchronized level holds a real sample.
module pwm_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall,
  output logic primed
);

  logic       meta;
  logic       prev;
  logic [1:0] fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      fill  <= '0;
    end else begin
      meta  <= d;
      level <= meta;
      prev  <= level;
      rise  <= level & ~prev;
      fall  <= ~level & prev;
      fill  <= {fill[0], 1'b1};
    end
  end

  assign primed = fill[1];

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM pulse-width decoder: measures high time and maps it
// to the 25..125 duty code with counters only.
module servo_pwm_decoder #(
  parameter int PULSE_MIN  = servo_pkg::PULSE_MIN,
  parameter int PULSE_MAX  = servo_pkg::PULSE_MAX,
  parameter int STEP       = servo_pkg::STEP,
  parameter int TOL        = servo_pkg::TOL,
  parameter int PERIOD_MAX = servo_pkg::PERIOD_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [6:0]  dc,
  output logic [19:0] pulse_width,
  output logic        valid,
  output logic        error,
  output logic        timeout,
  output logic        locked
);

  import servo_pkg::*;

  localparam int WW = 20;
  localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int PW = $clog2(PERIOD_MAX + 1);

  localparam logic [WW-1:0] W_SAT  = '1;
  localparam logic [WW-1:0] W_MIN  = WW'(PULSE_MIN);
  localparam logic [WW-1:0] W_LO   = WW'(PULSE_MIN - TOL);
  localparam logic [WW-1:0] W_HI   = WW'(PULSE_MAX + TOL);
  localparam logic [SW-1:0] S_LAST = SW'(STEP - 1);
  localparam logic [6:0]    U_MAX  = 7'(DC_MAX - DC_MIN);
  localparam logic [6:0]    DC_RST = 7'(DC_MIN);
  localparam logic [PW-1:0] P_MAX  = PW'(PERIOD_MAX);

  logic level, rise, fall, primed;

  state_t        state, state_nx;
  logic [WW-1:0] width, width_nx, w_inc;
  logic [SW-1:0] step, step_nx, s_inc;
  logic [6:0]    units, units_nx, u_inc;
  logic [PW-1:0] period, period_nx, p_inc;
  logic [1:0]    lock_cnt, lock_nx;
  logic          timeout_nx, valid_nx, error_nx;
  logic [6:0]    dc_nx;
  logic [WW-1:0] pw_nx;

  pwm_in_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall),
    .primed (primed)
  );

  always_comb begin
    state_nx   = state;
    width_nx   = width;
    step_nx    = step;
    units_nx   = units;
    lock_nx    = lock_cnt;
    timeout_nx = timeout;
    valid_nx   = 1'b0;
    error_nx   = 1'b0;
    dc_nx      = dc;
    pw_nx      = pulse_width;

    w_inc = (width == W_SAT) ? width : width + 1'b1;
    s_inc = step;
    u_inc = units;
    // step tracks (width - PULSE_MIN) mod STEP once past PULSE_MIN
    if (width >= W_MIN) begin
      if (step == S_LAST) begin
        s_inc = '0;
        if (units != U_MAX) u_inc = units + 7'd1;
      end else begin
        s_inc = step + 1'b1;
      end
    end

    p_inc     = (period == P_MAX) ? period : period + 1'b1;
    period_nx = rise ? '0 : p_inc;
    if (rise) timeout_nx = 1'b0;

    unique case (state)
      SYNC: begin
        if (primed && !level) state_nx = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          state_nx = HIGH;
          width_nx = '0;
          step_nx  = '0;
          units_nx = '0;
        end
      end
      HIGH: begin
        width_nx = w_inc;
        step_nx  = s_inc;
        units_nx = u_inc;
        if (fall) begin
          state_nx = WAIT_RISE;
          if (w_inc >= W_LO && w_inc <= W_HI) begin
            valid_nx = 1'b1;
            dc_nx    = DC_RST + u_inc;
            pw_nx    = w_inc;
            if (lock_cnt != 2'd2) lock_nx = lock_cnt + 2'd1;
          end else begin
            error_nx = 1'b1;
            lock_nx  = '0;
          end
        end
      end
      default: state_nx = SYNC;
    endcase

    // fires once, on the cycle the period counter reaches its limit
    if (!rise && p_inc == P_MAX && period != P_MAX) begin
      timeout_nx = 1'b1;
      lock_nx    = '0;
      state_nx   = SYNC;
    end

    if (!enable) begin
      state_nx   = SYNC;
      width_nx   = '0;
      step_nx    = '0;
      units_nx   = '0;
      period_nx  = '0;
      lock_nx    = '0;
      timeout_nx = 1'b0;
      valid_nx   = 1'b0;
      error_nx   = 1'b0;
      dc_nx      = dc;
      pw_nx      = pulse_width;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SYNC;
      width       <= '0;
      step        <= '0;
      units       <= '0;
      period      <= '0;
      lock_cnt    <= '0;
      timeout     <= 1'b0;
      valid       <= 1'b0;
      error       <= 1'b0;
      dc          <= DC_RST;
      pulse_width <= '0;
    end else begin
      state       <= state_nx;
      width       <= width_nx;
      step        <= step_nx;
      units       <= units_nx;
      period      <= period_nx;
      lock_cnt    <= lock_nx;
      timeout     <= timeout_nx;
      valid       <= valid_nx;
      error       <= error_nx;
      dc          <= dc_nx;
      pulse_width <= pw_nx;
    end
  end

  assign locked = (lock_cnt == 2'd2);

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder using a 1/100 time scale
// (PULSE_MIN=250, STEP=10, TOL=25, PERIOD_MAX=12000).
module tb_servo_pwm_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        pwm_in = 1'b0;
  logic [6:0]  dc;
  logic [19:0] pulse_width;
  logic        valid, error, timeout, locked;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int nv = 0;
  int ne = 0;
  int both = 0;
  int cap_dc = 0;
  int cap_pw = 0;
  int cap_lock = 0;
  int val_cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;

  servo_pwm_decoder #(
    .PULSE_MIN  (250),
    .PULSE_MAX  (1250),
    .STEP       (10),
    .TOL        (25),
    .PERIOD_MAX (12000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pwm_in      (pwm_in),
    .dc          (dc),
    .pulse_width (pulse_width),
    .valid       (valid),
    .error       (error),
    .timeout     (timeout),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      nv++;
      cap_dc   = dc;
      cap_pw   = pulse_width;
      cap_lock = locked;
      val_cyc  = cyc;
    end
    if (error) ne++;
    if (valid && error) both++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input int w, input int gap);
    @(posedge clk);
    #1 pwm_in = 1'b1;
    rise_cyc = cyc;
    repeat (w) @(posedge clk);
    #1 pwm_in = 1'b0;
    fall_cyc = cyc;
    repeat (gap) @(posedge clk);
  endtask

  task automatic good(input int w, input int edc);
    int v0, e0;
    v0 = nv;
    e0 = ne;
    pulse(w, 300);
    chk("valid_cnt", nv - v0, 1);
    chk("error_cnt", ne - e0, 0);
    chk("dc", cap_dc, edc);
    chk("pulse_width", cap_pw, w);
  endtask

  initial begin
    int v0, e0, t;

    repeat (3) @(negedge clk);
    chk("rst_dc", dc, 25);
    chk("rst_pw", pulse_width, 0);
    chk("rst_valid", valid, 0);
    chk("rst_error", error, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_locked", locked, 0);

    @(posedge clk);
    #1 rst = 1'b1;
    enable = 1'b1;
    repeat (10) @(posedge clk);

    good(250, 25);
    chk("valid_latency", val_cyc - fall_cyc, 4);
    chk("lock_after_1", cap_lock, 0);
    good(750, 75);
    chk("lock_after_2", cap_lock, 1);
    good(1250, 125);
    good(269, 26);
    good(225, 25);
    good(1275, 125);

    v0 = nv;
    e0 = ne;
    pulse(200, 300);
    chk("short_valid_cnt", nv - v0, 0);
    chk("short_error_cnt", ne - e0, 1);
    chk("short_dc_held", dc, 125);
    chk("short_pw_held", pulse_width, 1275);
    chk("short_unlock", locked, 0);

    good(750, 75);
    good(750, 75);
    chk("relock", locked, 1);

    t = 0;
    while (!timeout && t < 13000) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_set", timeout, 1);
    chk("timeout_latency", cyc - rise_cyc, 12004);
    chk("timeout_unlock", locked, 0);

    good(750, 75);
    chk("timeout_cleared", timeout, 0);

    @(posedge clk);
    #1 pwm_in = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_dc", dc, 25);
    chk("midrst_locked", locked, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    v0 = nv;
    e0 = ne;
    repeat (600) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (300) @(posedge clk);
    chk("midrst_no_valid", nv - v0, 0);
    chk("midrst_no_error", ne - e0, 0);
    good(750, 75);
    chk("midrst_lock1", locked, 0);
    good(500, 50);
    chk("midrst_lock2", locked, 1);

    v0 = nv;
    e0 = ne;
    @(posedge clk);
    #1 pwm_in = 1'b1;
    repeat (300) @(posedge clk);
    #1 enable = 1'b0;
    repeat (10) @(posedge clk);
    #1 enable = 1'b1;
    repeat (300) @(posedge clk);
    #1 pwm_in = 1'b0;
    repeat (300) @(posedge clk);
    chk("en_no_valid", nv - v0, 0);
    chk("en_no_error", ne - e0, 0);
    chk("en_unlock", locked, 0);
    chk("en_dc_held", dc, 50);
    good(350, 35);
    good(350, 35);
    chk("en_relock", locked, 1);

    chk("valid_error_excl", both, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
